sram_4_port_copy_engine: RTL and testbench

- Initiator-side block that drives all four ports of the 4-port SRAM: two read ports (C, D) and two write ports (A, B).
- Copies a block of LENGTH consecutive words from a source base address to a destination base address.
- Moves two words per clock, with read and write stages pipelined.
- Sits between a control/host master and the SRAM, using a Start/Busy/Done handshake on the host side.

---
 rtl/sram_4_port_copy_engine_pkg.sv | 16 +
 rtl/sram_4_port_copy_engine.sv | 135 +++++++++++++
 tb/tb_sram_4_port_copy_engine.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_4_port_copy_engine_pkg.sv
// Shared definitions for the 4-port SRAM copy engine: FSM states and
// default geometry constants.
package sram_copy_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_LEN_WIDTH  = DEFAULT_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sram_4_port_copy_engine.sv
// Block copy engine: reads two words per cycle on ports C/D and writes them
// one cycle later on ports A/B, with a Start/Busy/Done host handshake.
module sram_4_port_copy_engine
  import sram_copy_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Start_In,
  input  logic [ADDR_WIDTH-1:0] Src_Address_In,
  input  logic [ADDR_WIDTH-1:0] Dst_Address_In,
  input  logic [ADDR_WIDTH:0]   Length_In,
  output logic                  Busy_Out,
  output logic                  Done_Out,
  output logic [DATA_WIDTH-1:0] Port_W_A_Data_Out,
  output logic [ADDR_WIDTH-1:0] Port_W_A_Address_Out,
  output logic                  Port_W_A_Write_Enable_Out,
  output logic [DATA_WIDTH-1:0] Port_W_B_Data_Out,
  output logic [ADDR_WIDTH-1:0] Port_W_B_Address_Out,
  output logic                  Port_W_B_Write_Enable_Out,
  input  logic [DATA_WIDTH-1:0] Port_R_C_Data_In,
  output logic [ADDR_WIDTH-1:0] Port_R_C_Address_Out,
  output logic                  Port_R_C_Read_Enable_Out,
  input  logic [DATA_WIDTH-1:0] Port_R_D_Data_In,
  output logic [ADDR_WIDTH-1:0] Port_R_D_Address_Out,
  output logic                  Port_R_D_Read_Enable_Out
);

  localparam int LW = ADDR_WIDTH + 1;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] src_reg;
  logic [ADDR_WIDTH-1:0] dst_reg;
  logic [LW-1:0]         len_reg;
  logic [LW-1:0]         rd_off_reg;
  logic [LW-1:0]         next_off;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  rd_c_en_reg;
  logic                  rd_d_en_reg;
  logic [ADDR_WIDTH-1:0] rd_c_addr_reg;
  logic [ADDR_WIDTH-1:0] rd_d_addr_reg;
  logic                  wr_a_en_reg;
  logic                  wr_b_en_reg;
  logic [ADDR_WIDTH-1:0] wr_a_addr_reg;
  logic [ADDR_WIDTH-1:0] wr_b_addr_reg;

  assign next_off = rd_off_reg + LW'(2);

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      state_reg     <= ST_IDLE;
      src_reg       <= '0;
      dst_reg       <= '0;
      len_reg       <= '0;
      rd_off_reg    <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      rd_c_en_reg   <= 1'b0;
      rd_d_en_reg   <= 1'b0;
      rd_c_addr_reg <= '0;
      rd_d_addr_reg <= '0;
      wr_a_en_reg   <= 1'b0;
      wr_b_en_reg   <= 1'b0;
      wr_a_addr_reg <= '0;
      wr_b_addr_reg <= '0;
    end else begin
      // Write stage trails the read stage by exactly one cycle, so its
      // enables and addresses come from the read pair just issued.
      wr_a_en_reg   <= rd_c_en_reg;
      wr_b_en_reg   <= rd_d_en_reg;
      wr_a_addr_reg <= dst_reg + rd_off_reg[ADDR_WIDTH-1:0];
      wr_b_addr_reg <= dst_reg + rd_off_reg[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
      done_reg      <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (Start_In) begin
            if (Length_In == '0) begin
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              src_reg       <= Src_Address_In;
              dst_reg       <= Dst_Address_In;
              len_reg       <= Length_In;
              rd_off_reg    <= '0;
              rd_c_en_reg   <= 1'b1;
              rd_d_en_reg   <= (Length_In > LW'(1));
              rd_c_addr_reg <= Src_Address_In;
              rd_d_addr_reg <= Src_Address_In + ADDR_WIDTH'(1);
              busy_reg      <= 1'b1;
              state_reg     <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (next_off < len_reg) begin
            rd_off_reg    <= next_off;
            rd_c_addr_reg <= src_reg + next_off[ADDR_WIDTH-1:0];
            rd_d_addr_reg <= src_reg + next_off[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
            rd_d_en_reg   <= ((next_off + LW'(1)) < len_reg);
          end else begin
            rd_c_en_reg <= 1'b0;
            rd_d_en_reg <= 1'b0;
            state_reg   <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          done_reg  <= 1'b1;
          state_reg <= ST_DONE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign Busy_Out                  = busy_reg;
  assign Done_Out                  = done_reg;
  assign Port_R_C_Address_Out      = rd_c_addr_reg;
  assign Port_R_C_Read_Enable_Out  = rd_c_en_reg;
  assign Port_R_D_Address_Out      = rd_d_addr_reg;
  assign Port_R_D_Read_Enable_Out  = rd_d_en_reg;
  assign Port_W_A_Address_Out      = wr_a_addr_reg;
  assign Port_W_A_Write_Enable_Out = wr_a_en_reg;
  assign Port_W_B_Address_Out      = wr_b_addr_reg;
  assign Port_W_B_Write_Enable_Out = wr_b_en_reg;
  assign Port_W_A_Data_Out         = Port_R_C_Data_In;
  assign Port_W_B_Data_Out         = Port_R_D_Data_In;

endmodule

// File: tb/tb_sram_4_port_copy_engine.sv
// Directed bench for the copy engine; a behavioural 4-port SRAM responds to
// the engine and expected timelines are written out per scenario.
module tb_sram_4_port_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  src_addr = '0;
  logic [7:0]  dst_addr = '0;
  logic [8:0]  len = '0;
  logic        busy, done;
  logic [31:0] a_data, b_data, c_data, d_data;
  logic [7:0]  a_addr, b_addr, c_addr, d_addr;
  logic        a_we, b_we, c_en, d_en;

  logic [31:0] mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  int          wr_count = 0;
  int          rd_count = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  sram_4_port_copy_engine dut (
    .Clk_In                    (clk),
    .Reset_In                  (rst_n),
    .Start_In                  (start),
    .Src_Address_In            (src_addr),
    .Dst_Address_In            (dst_addr),
    .Length_In                 (len),
    .Busy_Out                  (busy),
    .Done_Out                  (done),
    .Port_W_A_Data_Out         (a_data),
    .Port_W_A_Address_Out      (a_addr),
    .Port_W_A_Write_Enable_Out (a_we),
    .Port_W_B_Data_Out         (b_data),
    .Port_W_B_Address_Out      (b_addr),
    .Port_W_B_Write_Enable_Out (b_we),
    .Port_R_C_Data_In          (c_data),
    .Port_R_C_Address_Out      (c_addr),
    .Port_R_C_Read_Enable_Out  (c_en),
    .Port_R_D_Data_In          (d_data),
    .Port_R_D_Address_Out      (d_addr),
    .Port_R_D_Read_Enable_Out  (d_en)
  );

  // SRAM responder: read data valid the cycle after the enable
  always @(posedge clk) begin
    if (c_en) c_data <= mem[c_addr];
    if (d_en) d_data <= mem[d_addr];
    if (a_we) mem[a_addr] <= a_data;
    if (b_we) mem[b_addr] <= b_data;
    if (pre_we) mem[pre_addr] <= pre_data;
    wr_count <= wr_count + (a_we ? 1 : 0) + (b_we ? 1 : 0);
    rd_count <= rd_count + (c_en ? 1 : 0) + (d_en ? 1 : 0);
  end

  task automatic preload(input logic [7:0] base, input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      pre_we   = 1'b1;
      pre_addr = base + 8'(i);
      pre_data = first + 32'(i);
      @(negedge clk);
    end
    pre_we = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge: drives Start for cycle 0, returns at the cycle 1 sample point
  task automatic do_start(input logic [7:0] s, input logic [7:0] d, input logic [8:0] n);
    start    = 1'b1;
    src_addr = s;
    dst_addr = d;
    len      = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] ctl;
    @(negedge clk);
    ctl = {busy, done, c_en, d_en, a_we, b_we};
    checks++;
    if (ctl !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 000000", ctl);
    end
    checks++;
    if ({a_addr, b_addr, c_addr, d_addr} !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr: got %h want 00000000", {a_addr, b_addr, c_addr, d_addr});
    end
    $display("reset: ctl=%b addrs=%h", ctl, {a_addr, b_addr, c_addr, d_addr});
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [5:0]  exp_ctl, got_ctl;
    logic [7:0]  ea;
    logic [31:0] ed;
    preload(8'h10, 32'hA0, 4);
    do_start(8'h10, 8'h80, 9'd4);
    for (int c = 1; c <= 5; c++) begin
      exp_ctl = {(c <= 4), (c == 4), (c <= 2), (c <= 2), (c >= 2 && c <= 3), (c >= 2 && c <= 3)};
      got_ctl = {busy, done, c_en, d_en, a_we, b_we};
      checks++;
      if (got_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL basic_ctl c%0d: got %b want %b", c, got_ctl, exp_ctl);
      end
      if (c <= 2) begin
        ea = 8'h10 + 8'(2 * (c - 1));
        checks++;
        if ({c_addr, d_addr} !== {ea, ea + 8'd1}) begin
          errors++;
          $display("FAIL basic_rd_addr c%0d: got %h/%h want %h/%h", c, c_addr, d_addr, ea, ea + 8'd1);
        end
      end
      if (c >= 2 && c <= 3) begin
        ea = 8'h80 + 8'(2 * (c - 2));
        ed = 32'hA0 + 32'(2 * (c - 2));
        checks++;
        if ({a_addr, b_addr, a_data, b_data} !== {ea, ea + 8'd1, ed, ed + 32'd1}) begin
          errors++;
          $display("FAIL basic_wr c%0d: got %h/%h %h/%h want %h/%h %h/%h",
                   c, a_addr, b_addr, a_data, b_data, ea, ea + 8'd1, ed, ed + 32'd1);
        end
      end
      $display("basic c%0d: ctl=%b rd=%h/%h wr=%h/%h", c, got_ctl, c_addr, d_addr, a_addr, b_addr);
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      ea = 8'h80 + 8'(i);
      checks++;
      if (mem[ea] !== 32'hA0 + 32'(i)) begin
        errors++;
        $display("FAIL basic_mem[%h]: got %h want %h", ea, mem[ea], 32'hA0 + 32'(i));
      end
    end
    $display("basic mem 80..83 = %h %h %h %h", mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]);
  endtask

  task automatic test_odd_length();
    preload(8'h20, 32'hB0, 5);
    preload(8'h45, 32'hDEAD, 1);
    do_start(8'h20, 8'h40, 9'd5);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({c_en, d_en, c_addr} !== {1'b1, 1'b0, 8'h24}) begin
      errors++;
      $display("FAIL odd_last_read: got c_en=%b d_en=%b c_addr=%h want 1 0 24", c_en, d_en, c_addr);
    end
    $display("odd c3: c_en=%b d_en=%b c_addr=%h", c_en, d_en, c_addr);
    @(negedge clk);
    checks++;
    if ({a_we, b_we, a_addr, a_data} !== {1'b1, 1'b0, 8'h44, 32'hB4}) begin
      errors++;
      $display("FAIL odd_last_write: got a_we=%b b_we=%b a_addr=%h a_data=%h want 1 0 44 b4",
               a_we, b_we, a_addr, a_data);
    end
    $display("odd c4: a_we=%b b_we=%b a_addr=%h a_data=%h", a_we, b_we, a_addr, a_data);
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b11) begin
      errors++;
      $display("FAIL odd_done_c5: got busy=%b done=%b want 1 1", busy, done);
    end
    @(negedge clk);
    checks++;
    if ({mem[8'h40], mem[8'h44], mem[8'h45]} !== {32'hB0, 32'hB4, 32'hDEAD}) begin
      errors++;
      $display("FAIL odd_mem: got %h %h %h want b0 b4 dead", mem[8'h40], mem[8'h44], mem[8'h45]);
    end
    $display("odd mem 40=%h 44=%h 45=%h", mem[8'h40], mem[8'h44], mem[8'h45]);
  endtask

  task automatic test_wrap();
    logic [7:0] ea;
    preload(8'hFE, 32'hC0, 4);
    do_start(8'hFE, 8'h10, 9'd4);
    checks++;
    if ({c_addr, d_addr} !== 16'hFEFF) begin
      errors++;
      $display("FAIL wrap_rd_c1: got %h/%h want fe/ff", c_addr, d_addr);
    end
    @(negedge clk);
    checks++;
    if ({c_addr, d_addr} !== 16'h0001) begin
      errors++;
      $display("FAIL wrap_rd_c2: got %h/%h want 00/01", c_addr, d_addr);
    end
    for (int i = 0; i < 4; i++) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ea = 8'h10 + 8'(i);
      checks++;
      if (mem[ea] !== 32'hC0 + 32'(i)) begin
        errors++;
        $display("FAIL wrap_mem[%h]: got %h want %h", ea, mem[ea], 32'hC0 + 32'(i));
      end
    end
    $display("wrap mem 10..13 = %h %h %h %h", mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]);
  endtask

  task automatic test_zero_length();
    int rd0, wr0;
    logic any_en, any_busy;
    rd0 = rd_count;
    wr0 = wr_count;
    any_en = 1'b0;
    any_busy = 1'b0;
    do_start(8'h00, 8'h00, 9'd0);
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++;
      $display("FAIL zero_c1: got busy=%b done=%b want 0 1", busy, done);
    end
    for (int c = 1; c <= 4; c++) begin
      any_en   = any_en | c_en | d_en | a_we | b_we;
      any_busy = any_busy | busy;
      @(negedge clk);
    end
    checks++;
    if ({any_en, any_busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL zero_quiet: got en=%b busy=%b done=%b want 0 0 0", any_en, any_busy, done);
    end
    checks++;
    if ((rd_count - rd0) + (wr_count - wr0) != 0) begin
      errors++;
      $display("FAIL zero_access: got %0d accesses want 0", (rd_count - rd0) + (wr_count - wr0));
    end
    $display("zero: en=%b busy=%b accesses=%0d", any_en, any_busy, (rd_count - rd0) + (wr_count - wr0));
  endtask

  task automatic test_back_to_back();
    int wr0, pulses, done_cycle;
    wr0 = wr_count;
    pulses = 0;
    done_cycle = -1;
    do_start(8'h30, 8'h60, 9'd6);
    for (int c = 1; c <= 8; c++) begin
      if (done) begin
        pulses++;
        done_cycle = c;
      end
      start    = (c == 2 || c == 3);
      src_addr = 8'h90;
      len      = 9'd2;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (pulses != 1 || done_cycle != 5) begin
      errors++;
      $display("FAIL restart_done: got %0d pulses at c%0d want 1 at c5", pulses, done_cycle);
    end
    checks++;
    if (wr_count - wr0 != 6) begin
      errors++;
      $display("FAIL restart_writes: got %0d want 6", wr_count - wr0);
    end
    $display("restart: pulses=%0d done_cycle=%0d writes=%0d", pulses, done_cycle, wr_count - wr0);
  endtask

  task automatic test_reset_mid_copy();
    int rd0, wr0, done_cycle;
    logic [7:0] ea;
    preload(8'h50, 32'hD0, 8);
    do_start(8'h50, 8'h70, 9'd8);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rd0 = rd_count;
    wr0 = wr_count;
    checks++;
    if ({busy, done, c_en, d_en, a_we, b_we} !== 6'b0) begin
      errors++;
      $display("FAIL midreset_ctl: got %b want 000000", {busy, done, c_en, d_en, a_we, b_we});
    end
    for (int i = 0; i < 4; i++) @(negedge clk);
    checks++;
    if (wr_count != wr0 || rd_count != rd0) begin
      errors++;
      $display("FAIL midreset_quiet: got %0d writes %0d reads want 0 0", wr_count - wr0, rd_count - rd0);
    end
    $display("midreset: accesses after reset wr=%0d rd=%0d", wr_count - wr0, rd_count - rd0);
    rst_n = 1'b1;
    @(negedge clk);
    done_cycle = -1;
    do_start(8'h50, 8'h70, 9'd8);
    for (int c = 1; c <= 8; c++) begin
      if (done && done_cycle < 0) done_cycle = c;
      @(negedge clk);
    end
    checks++;
    if (done_cycle != 6) begin
      errors++;
      $display("FAIL midreset_redo_done: got c%0d want c6", done_cycle);
    end
    for (int i = 0; i < 8; i++) begin
      ea = 8'h70 + 8'(i);
      checks++;
      if (mem[ea] !== 32'hD0 + 32'(i)) begin
        errors++;
        $display("FAIL midreset_mem[%h]: got %h want %h", ea, mem[ea], 32'hD0 + 32'(i));
      end
    end
    $display("midreset redo: done c%0d mem 70=%h 77=%h", done_cycle, mem[8'h70], mem[8'h77]);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_length();
    test_wrap();
    test_zero_length();
    test_back_to_back();
    test_reset_mid_copy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
